// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared constants and action encoding for the program-fetch sequencer
package fetch_ctrl_pkg;
  localparam int AW = 10;
  localparam int MEM_DEPTH = 1 << AW;
  localparam logic [AW-1:0] RESET_VEC = 10'd0;
  localparam logic [AW-1:0] INT_VEC = 10'd1;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INT,
    ACT_RETI,
    ACT_RET,
    ACT_CALL,
    ACT_JUMP,
    ACT_INC
  } act_e;
endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - sequencing requests from decode and fetch-side status back to it
interface fetch_ctrl_if #(
  parameter int AW = 10
);
  logic          stall;
  logic          jump;
  logic          call;
  logic          ret;
  logic [AW-1:0] target;
  logic          int_req;
  logic          reti;
  logic [AW-1:0] pc;
  logic          int_ack;
  logic          in_isr;
  logic          stk_ovf;
  logic          stk_unf;

  modport master (
    output stall, jump, call, ret, target, int_req, reti,
    input  pc, int_ack, in_isr, stk_ovf, stk_unf
  );

  modport slave (
    input  stall, jump, call, ret, target, int_req, reti,
    output pc, int_ack, in_isr, stk_ovf, stk_unf
  );
endinterface

// File: rtl/fetch_ctrl_ret_stack.sv
// rtl/fetch_ctrl_ret_stack.sv - return-address stack with sticky overflow/underflow detect
module ret_stack #(
  parameter int AW     = 10,
  parameter int SDEPTH = 8,
  localparam int IW    = $clog2(SDEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] push_data_i,
  output logic [AW-1:0] top_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o,
  output logic          unf_o
);
  logic [AW-1:0] mem_q [SDEPTH];
  logic [IW:0]   sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [IW-1:0] top_idx;

  assign full_o  = (sp_q == (IW+1)'(SDEPTH));
  assign empty_o = (sp_q == '0);
  // When empty this index wraps; the caller ignores top_o in that case.
  assign top_idx = IW'(sp_q - 1'b1);
  assign top_o   = mem_q[top_idx];
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push_i) begin
      if (full_o) ovf_d = 1'b1;
      else        sp_d  = sp_q + 1'b1;
    end else if (pop_i) begin
      if (empty_o) unf_d = 1'b1;
      else         sp_d  = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_i && !full_o) mem_q[sp_q[IW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC register, request priority encoder and interrupt entry/exit
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int            AW        = fetch_ctrl_pkg::AW,
  parameter int            SDEPTH    = 8,
  parameter logic [AW-1:0] RESET_VEC = fetch_ctrl_pkg::RESET_VEC,
  parameter logic [AW-1:0] INT_VEC   = fetch_ctrl_pkg::INT_VEC
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic          in_isr_q, in_isr_d;
  logic          int_ack_q, int_ack_d;
  logic          push, pop;
  logic [AW-1:0] push_data, stk_top;
  logic          stk_full, stk_empty, stk_ovf, stk_unf;
  act_e          act;

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    act = ACT_INC;
    if (bus.stall)                        act = ACT_HOLD;
    else if (bus.int_req && !in_isr_q)    act = ACT_INT;
    else if (bus.reti)                    act = ACT_RETI;
    else if (bus.ret)                     act = ACT_RET;
    else if (bus.call)                    act = ACT_CALL;
    else if (bus.jump)                    act = ACT_JUMP;
  end

  always_comb begin
    pc_d      = pc_q;
    in_isr_d  = in_isr_q;
    int_ack_d = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    case (act)
      ACT_HOLD: ;
      // The interrupted instruction has not executed yet, so pc itself is saved.
      ACT_INT: begin
        push      = 1'b1;
        push_data = pc_q;
        pc_d      = INT_VEC;
        in_isr_d  = 1'b1;
        int_ack_d = 1'b1;
      end
      ACT_RETI: begin
        pop      = 1'b1;
        pc_d     = stk_empty ? pc_inc : stk_top;
        in_isr_d = 1'b0;
      end
      ACT_RET: begin
        pop  = 1'b1;
        pc_d = stk_empty ? pc_inc : stk_top;
      end
      ACT_CALL: begin
        push = 1'b1;
        pc_d = bus.target;
      end
      ACT_JUMP: pc_d = bus.target;
      default:  pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_VEC;
      in_isr_q  <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      in_isr_q  <= in_isr_d;
      int_ack_q <= int_ack_d;
    end
  end

  ret_stack #(
    .AW     (AW),
    .SDEPTH (SDEPTH)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .top_o       (stk_top),
    .full_o      (stk_full),
    .empty_o     (stk_empty),
    .ovf_o       (stk_ovf),
    .unf_o       (stk_unf)
  );

  assign bus.pc      = pc_q;
  assign bus.int_ack = int_ack_q;
  assign bus.in_isr  = in_isr_q;
  assign bus.stk_ovf = stk_ovf;
  assign bus.stk_unf = stk_unf;
endmodule
